// File: rtl/stage_if_pkg.sv
// Shared constants for the instruction-fetch stage.
//   DATA_WID   : width of every address / instruction field
//   NOP_INST   : instruction shown to decode when the IF/ID slot is empty
//   INST_BYTES : byte stride between sequential instructions
//   align_pc() : forces a redirect target onto a word boundary
package stage_if_pkg;

    localparam int                  DATA_WID   = 32;
    localparam logic [DATA_WID-1:0] NOP_INST   = 32'h0000_0013;
    localparam logic [DATA_WID-1:0] INST_BYTES = 32'd4;

    function automatic logic [DATA_WID-1:0] align_pc(input logic [DATA_WID-1:0] a);
        return a & ~(INST_BYTES - 32'd1);
    endfunction

endpackage

// File: rtl/stage_if_if.sv
// Bundle of signals between the fetch stage, its instruction memory and the
// decode stage.
//   master : the fetch stage (drives imem_addr, pc_out, inst_out, counters)
//   slave  : memory / decode side (drives imem_data, stall, redirect inputs)
interface stage_if_if
    import stage_if_pkg::*;
#(
    parameter int CNT_WID = 32
) ();

    logic [DATA_WID-1:0] imem_addr;
    logic [DATA_WID-1:0] imem_data;
    logic                PC_Write;
    logic                IF_ID_Write;
    logic                predict_result;
    logic                predict_fail;
    logic [DATA_WID-1:0] new_pc;
    logic [DATA_WID-1:0] pc_out;
    logic [DATA_WID-1:0] inst_out;
    logic [CNT_WID-1:0]  fetch_cnt;
    logic [CNT_WID-1:0]  flush_cnt;

    modport master (
        output imem_addr,
        input  imem_data,
        input  PC_Write,
        input  IF_ID_Write,
        input  predict_result,
        input  predict_fail,
        input  new_pc,
        output pc_out,
        output inst_out,
        output fetch_cnt,
        output flush_cnt
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output PC_Write,
        output IF_ID_Write,
        output predict_result,
        output predict_fail,
        output new_pc,
        input  pc_out,
        input  inst_out,
        input  fetch_cnt,
        input  flush_cnt
    );

endinterface

// File: rtl/stage_if_fetch_hold_buf.sv
// Hold register for the instruction in the IF/ID slot during a stall.
// The memory returns data for the address issued one cycle earlier, so once
// a stall starts only the first cycle's imem_data belongs to the instruction
// in IF/ID; it is captured then and replayed until the stall ends.
//   clk, rst     : clock, synchronous active-high reset
//   i_capture    : stall cycle (capture if nothing is held yet)
//   i_clear      : advance or flush, drop any held data
//   i_id_vld     : IF/ID slot holds a real instruction
//   i_imem_data  : instruction memory read data
//   o_inst       : instruction presented to decode
module stage_if_fetch_hold_buf
    import stage_if_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_capture,
    input  logic                i_clear,
    input  logic                i_id_vld,
    input  logic [DATA_WID-1:0] i_imem_data,
    output logic [DATA_WID-1:0] o_inst
);

    logic                r_hold_vld_p1;
    logic [DATA_WID-1:0] r_hold_inst_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_vld_p1 <= 1'b0;
        end else if (i_clear) begin
            r_hold_vld_p1 <= 1'b0;
        end else if (i_capture) begin
            r_hold_vld_p1 <= 1'b1;
        end
    end

    // Only the first stall cycle is captured; later cycles carry data for pc_q.
    always_ff @(posedge clk) begin
        if (i_capture && !i_clear && !r_hold_vld_p1) begin
            r_hold_inst_p1 <= i_imem_data;
        end
    end

    assign o_inst = !i_id_vld     ? NOP_INST       :
                    r_hold_vld_p1 ? r_hold_inst_p1 : i_imem_data;

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: owns the PC and IF/ID registers, drives a
// 1-cycle-latency instruction memory and hands pc/inst pairs to decode.
//   clk, rst       : clock, synchronous active-high reset
//   bus.imem_addr  : fetch address (= pc_q)
//   bus.imem_data  : instruction for the previous cycle's address
//   bus.PC_Write / bus.IF_ID_Write : either low stalls the stage
//   bus.predict_result : taken-branch redirect (ignored while stalled)
//   bus.predict_fail   : misprediction flush, overrides stall
//   bus.new_pc     : redirect target, low two bits dropped
//   bus.pc_out / bus.inst_out : pair presented to decode
//   bus.fetch_cnt / bus.flush_cnt : performance counters (wrap)
module stage_if
    import stage_if_pkg::*;
#(
    parameter logic [DATA_WID-1:0] RESET_PC = 32'h0000_0000,
    parameter int                  CNT_WID  = 32
) (
    input  logic      clk,
    input  logic      rst,
    stage_if_if.master bus
);

    logic [DATA_WID-1:0] r_pc_p0;
    logic [DATA_WID-1:0] r_id_pc_p1;
    logic                r_id_vld_p1;
    logic [CNT_WID-1:0]  r_fetch_cnt;
    logic [CNT_WID-1:0]  r_flush_cnt;

    logic                w_stall;
    logic                w_hold_clr;
    logic                w_hold_cap;
    logic [DATA_WID-1:0] w_new_pc;
    logic [DATA_WID-1:0] w_inst;

    assign w_stall    = !bus.PC_Write || !bus.IF_ID_Write;
    assign w_new_pc   = align_pc(bus.new_pc);
    assign w_hold_clr = bus.predict_fail || !w_stall;
    assign w_hold_cap = w_stall && !bus.predict_fail;

    // p0 -> p1: issued address becomes the IF/ID entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_p0     <= RESET_PC;
            r_id_pc_p1  <= '0;
            r_id_vld_p1 <= 1'b0;
            r_fetch_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (bus.predict_fail) begin
            r_pc_p0     <= w_new_pc;
            r_id_vld_p1 <= 1'b0;
            r_flush_cnt <= r_flush_cnt + CNT_WID'(1);
        end else if (bus.predict_result && !w_stall) begin
            // The branch in IF/ID is consumed; the sequential fetch behind it is squashed.
            r_pc_p0     <= w_new_pc;
            r_id_vld_p1 <= 1'b0;
            r_fetch_cnt <= r_fetch_cnt + CNT_WID'(r_id_vld_p1);
            r_flush_cnt <= r_flush_cnt + CNT_WID'(1);
        end else if (!w_stall) begin
            r_pc_p0     <= r_pc_p0 + INST_BYTES;
            r_id_pc_p1  <= r_pc_p0;
            r_id_vld_p1 <= 1'b1;
            r_fetch_cnt <= r_fetch_cnt + CNT_WID'(r_id_vld_p1);
        end
    end

    stage_if_fetch_hold_buf u_hold (
        .clk         (clk),
        .rst         (rst),
        .i_capture   (w_hold_cap),
        .i_clear     (w_hold_clr),
        .i_id_vld    (r_id_vld_p1),
        .i_imem_data (bus.imem_data),
        .o_inst      (w_inst)
    );

    assign bus.imem_addr = r_pc_p0;
    assign bus.pc_out    = r_id_pc_p1;
    assign bus.inst_out  = w_inst;
    assign bus.fetch_cnt = r_fetch_cnt;
    assign bus.flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if. Memory content is mem[addr] = addr + 0x100, so the
// instruction expected for any presented pc is pc + 0x100. The reference
// model tracks only the architectural view: next fetch address, the pc in
// the decode slot (or empty), and the two counters.
module tb_stage_if;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;

    stage_if_if #(.CNT_WID(32)) bus ();

    stage_if #(.RESET_PC(RST_PC), .CNT_WID(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory, 1-cycle latency.
    always_ff @(posedge clk) bus.imem_data <= bus.imem_addr + 32'h100;

    int nchk = 0;
    int nerr = 0;

    // Reference model state
    logic [31:0] m_next;
    logic [31:0] m_id_pc;
    logic        m_vld;
    logic [31:0] m_fetch;
    logic [31:0] m_flush;

    logic [159:0] act;

    function automatic logic [159:0] exp_vec();
        return {m_next, m_id_pc, (m_vld ? m_id_pc + 32'h100 : NOP), m_fetch, m_flush};
    endfunction

    // Apply one cycle of inputs, advance the model, return at the next negedge.
    task automatic tick(input logic r, input logic pw, input logic iw,
                        input logic pr, input logic pf, input logic [31:0] npc);
        logic st;
        rst                = r;
        bus.PC_Write       = pw;
        bus.IF_ID_Write    = iw;
        bus.predict_result = pr;
        bus.predict_fail   = pf;
        bus.new_pc         = npc;
        @(posedge clk);
        st = !pw || !iw;
        if (r) begin
            m_next = RST_PC; m_id_pc = '0; m_vld = 1'b0; m_fetch = '0; m_flush = '0;
        end else if (pf) begin
            m_next = npc & ~32'h3; m_vld = 1'b0; m_flush++;
        end else if (pr && !st) begin
            if (m_vld) m_fetch++;
            m_next = npc & ~32'h3; m_vld = 1'b0; m_flush++;
        end else if (!st) begin
            if (m_vld) m_fetch++;
            m_id_pc = m_next; m_vld = 1'b1; m_next = m_next + 32'd4;
        end
        @(negedge clk);
    endtask

    task automatic go(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        do_reset();
        nchk++;
        if (bus.inst_out !== NOP) begin
            nerr++; $display("FAIL reset_inst: got %h want %h", bus.inst_out, NOP);
        end
        nchk++;
        if (bus.imem_addr !== RST_PC) begin
            nerr++; $display("FAIL reset_addr: got %h want %h", bus.imem_addr, RST_PC);
        end
        nchk++;
        if (bus.fetch_cnt !== 32'd0 || bus.flush_cnt !== 32'd0) begin
            nerr++; $display("FAIL reset_cnt: got %h/%h want 0/0", bus.fetch_cnt, bus.flush_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            go(1);
            nchk++;
            if (bus.pc_out !== 32'(k * 4) || bus.inst_out !== 32'(32'h100 + k * 4)) begin
                nerr++;
                $display("FAIL seq_fetch[%0d]: got pc=%h inst=%h want pc=%h inst=%h",
                         k, bus.pc_out, bus.inst_out, 32'(k * 4), 32'(32'h100 + k * 4));
            end
        end
        nchk++;
        if (bus.fetch_cnt !== 32'd3) begin
            nerr++; $display("FAIL seq_fetch_cnt: got %0d want 3", bus.fetch_cnt);
        end
    endtask

    task automatic test_stall();
        do_reset();
        go(3);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            nchk++;
            if (bus.pc_out !== 32'h8 || bus.inst_out !== 32'h108 || bus.imem_addr !== 32'hC) begin
                nerr++;
                $display("FAIL stall_hold[%0d]: got pc=%h inst=%h addr=%h want pc=8 inst=108 addr=c",
                         k, bus.pc_out, bus.inst_out, bus.imem_addr);
            end
        end
        go(1);
        nchk++;
        if (bus.pc_out !== 32'hC || bus.inst_out !== 32'h10C) begin
            nerr++; $display("FAIL stall_resume1: got pc=%h inst=%h want pc=c inst=10c", bus.pc_out, bus.inst_out);
        end
        go(1);
        nchk++;
        if (bus.pc_out !== 32'h10 || bus.inst_out !== 32'h110) begin
            nerr++; $display("FAIL stall_resume2: got pc=%h inst=%h want pc=10 inst=110", bus.pc_out, bus.inst_out);
        end
        act = {bus.imem_addr, bus.pc_out, bus.inst_out, bus.fetch_cnt, bus.flush_cnt};
        nchk++;
        if (act !== exp_vec()) begin
            nerr++; $display("FAIL stall_model: got %h want %h", act, exp_vec());
        end
    endtask

    task automatic test_redirect();
        do_reset();
        go(2);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40);
        nchk++;
        if (bus.inst_out !== NOP || bus.flush_cnt !== 32'd1) begin
            nerr++; $display("FAIL redirect_squash: got inst=%h flush=%0d want inst=%h flush=1",
                             bus.inst_out, bus.flush_cnt, NOP);
        end
        go(1);
        nchk++;
        if (bus.pc_out !== 32'h40 || bus.inst_out !== 32'h140) begin
            nerr++; $display("FAIL redirect_target: got pc=%h inst=%h want pc=40 inst=140", bus.pc_out, bus.inst_out);
        end
        act = {bus.imem_addr, bus.pc_out, bus.inst_out, bus.fetch_cnt, bus.flush_cnt};
        nchk++;
        if (act !== exp_vec()) begin
            nerr++; $display("FAIL redirect_model: got %h want %h", act, exp_vec());
        end
    endtask

    task automatic test_fail_over_stall();
        do_reset();
        go(3);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h22);
        nchk++;
        if (bus.inst_out !== NOP || bus.imem_addr !== 32'h20 || bus.flush_cnt !== 32'd1) begin
            nerr++; $display("FAIL fail_flush: got inst=%h addr=%h flush=%0d want inst=%h addr=20 flush=1",
                             bus.inst_out, bus.imem_addr, bus.flush_cnt, NOP);
        end
        go(1);
        nchk++;
        if (bus.pc_out !== 32'h20 || bus.inst_out !== 32'h120) begin
            nerr++; $display("FAIL fail_target: got pc=%h inst=%h want pc=20 inst=120", bus.pc_out, bus.inst_out);
        end
    endtask

    task automatic test_pr_in_stall();
        do_reset();
        go(2);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80);
        nchk++;
        if (bus.pc_out !== 32'h4 || bus.inst_out !== 32'h104 || bus.imem_addr !== 32'h8 ||
            bus.flush_cnt !== 32'd0) begin
            nerr++; $display("FAIL pr_stall_ignored: got pc=%h inst=%h addr=%h flush=%0d want pc=4 inst=104 addr=8 flush=0",
                             bus.pc_out, bus.inst_out, bus.imem_addr, bus.flush_cnt);
        end
        go(1);
        nchk++;
        if (bus.pc_out !== 32'h8 || bus.inst_out !== 32'h108) begin
            nerr++; $display("FAIL pr_stall_resume: got pc=%h inst=%h want pc=8 inst=108", bus.pc_out, bus.inst_out);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        go(1);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        go(1);
        nchk++;
        if (bus.pc_out !== 32'hFFFF_FFFC || bus.inst_out !== 32'h0000_00FC || bus.imem_addr !== 32'h0) begin
            nerr++; $display("FAIL wrap_top: got pc=%h inst=%h addr=%h want pc=fffffffc inst=fc addr=0",
                             bus.pc_out, bus.inst_out, bus.imem_addr);
        end
        go(1);
        nchk++;
        if (bus.pc_out !== 32'h0 || bus.inst_out !== 32'h100) begin
            nerr++; $display("FAIL wrap_zero: got pc=%h inst=%h want pc=0 inst=100", bus.pc_out, bus.inst_out);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        go(4);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h60);
        nchk++;
        if (bus.imem_addr !== RST_PC || bus.inst_out !== NOP || bus.fetch_cnt !== 32'd0 ||
            bus.flush_cnt !== 32'd0) begin
            nerr++; $display("FAIL reset_mid_stall: got addr=%h inst=%h cnt=%0d/%0d want addr=%h inst=%h cnt=0/0",
                             bus.imem_addr, bus.inst_out, bus.fetch_cnt, bus.flush_cnt, RST_PC, NOP);
        end
    endtask

    task automatic test_random();
        logic r, pw, iw, pr, pf;
        logic [31:0] npc;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 99) < 2);
            pf  = ($urandom_range(0, 99) < 8);
            pr  = ($urandom_range(0, 99) < 15);
            pw  = ($urandom_range(0, 99) >= 20);
            iw  = ($urandom_range(0, 99) >= 10);
            npc = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
            tick(r, pw, iw, pr, pf, npc);
            act = {bus.imem_addr, bus.pc_out, bus.inst_out, bus.fetch_cnt, bus.flush_cnt};
            nchk++;
            if (act !== exp_vec()) begin
                nerr++; $display("FAIL random[%0d]: got %h want %h", i, act, exp_vec());
            end
        end
    endtask

    initial begin
        rst                = 1'b1;
        bus.PC_Write       = 1'b1;
        bus.IF_ID_Write    = 1'b1;
        bus.predict_result = 1'b0;
        bus.predict_fail   = 1'b0;
        bus.new_pc         = 32'h0;
        @(negedge clk);
        test_reset();
        test_stall();
        test_redirect();
        test_fail_over_stall();
        test_pr_in_stall();
        test_wrap();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
